// File: rtl/effect_ctrl.sv
// effect_ctrl: three-button effect selector / parameter editor.
//
// Buttons are synchronised and debounced, then turned into single-cycle press
// pulses. In SELECT, L/R move the selected slot and C enters EDIT. In EDIT the
// selected LED blinks and a second C stores sw_param into the selected slot.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   btn_in     raw buttons: [2]=L, [1]=C, [0]=R
//   sw_en      effect enable switches
//   sw_param   parameter value switches
//   fx_en      registered copy of sw_en (one cycle latency)
//   options    slot k parameter at [k*PARAM_W +: PARAM_W]
//   sel        selected slot index
//   leds       selection indicator, bit N_FX-1-sel lit
//   edit_mode  high while in EDIT
//   param_wr   one-cycle pulse when a slot is written
//
// Build option
//   EFFECT_CTRL_WRAP_EN  when defined, sel wraps at both ends instead of
//                        saturating.

module effect_ctrl #(
    parameter int unsigned N_FX         = 4,
    parameter int unsigned PARAM_W      = 4,
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned BLINK_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                btn_in,
    input  logic [N_FX-1:0]           sw_en,
    input  logic [PARAM_W-1:0]        sw_param,
    output logic [N_FX-1:0]           fx_en,
    output logic [N_FX*PARAM_W-1:0]   options,
    output logic [$clog2(N_FX)-1:0]   sel,
    output logic [N_FX-1:0]           leds,
    output logic                      edit_mode,
    output logic                      param_wr
);

    localparam int unsigned SEL_W = $clog2(N_FX);
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam int unsigned BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam int unsigned OPT_W = N_FX * PARAM_W;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_C = 1;
    localparam int unsigned BTN_R = 0;

    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_FX - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [N_FX-1:0]  LED_SLOT0 = {1'b1, {(N_FX - 1){1'b0}}};

    typedef enum logic [0:0] {
        S_SELECT = 1'b0,
        S_EDIT   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Button front end
    // ------------------------------------------------------------------
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [1:0]       warm;      // marks when sync2 carries real samples
    logic [2:0]       deb;
    logic [2:0]       armed;     // button has been seen released since reset
    logic [2:0]       press_q;
    logic [CNT_W-1:0] deb_cnt [3];
    logic [CNT_W-1:0] rel_cnt [3];

    // Synchroniser, debouncer, release-arming and press-pulse generation.
    // A button held through reset only arms after DEB_CYCLES real low
    // samples, so its first debounced rise after reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            warm    <= '0;
            deb     <= '0;
            armed   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
                rel_cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn_in;
            sync2   <= sync1;
            warm    <= {warm[0], 1'b1};
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                // counts consecutive samples that disagree with the level
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        press_q[i] <= sync2[i] & armed[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end

                if (!armed[i]) begin
                    if (warm[1] && !sync2[i]) begin
                        if (rel_cnt[i] == DEB_LAST) begin
                            armed[i]   <= 1'b1;
                            rel_cnt[i] <= '0;
                        end else begin
                            rel_cnt[i] <= rel_cnt[i] + CNT_W'(1);
                        end
                    end else begin
                        rel_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Simultaneous presses cancel each other.
    logic press_one;
    logic press_l;
    logic press_c;
    logic press_r;

    assign press_one = $onehot(press_q);
    assign press_l   = press_one & press_q[BTN_L];
    assign press_c   = press_one & press_q[BTN_C];
    assign press_r   = press_one & press_q[BTN_R];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] sel_d;
    logic [OPT_W-1:0] options_d;
    logic [N_FX-1:0]  leds_d;
    logic             param_wr_d;
    logic [BLK_W-1:0] blink_cnt;
    logic [BLK_W-1:0] blink_cnt_d;
    logic             blink_on;
    logic             blink_on_d;

    // Next state, slot write and LED pattern.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel;
        options_d   = options;
        param_wr_d  = 1'b0;
        blink_cnt_d = blink_cnt;
        blink_on_d  = blink_on;

        unique case (state_q)
            S_SELECT: begin
                if (press_c) begin
                    state_d     = S_EDIT;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end else if (press_r) begin
                    if (sel == SEL_LAST) begin
`ifdef EFFECT_CTRL_WRAP_EN
                        sel_d = '0;
`else
                        sel_d = sel;
`endif
                    end else begin
                        sel_d = sel + SEL_W'(1);
                    end
                end else if (press_l) begin
                    if (sel == '0) begin
`ifdef EFFECT_CTRL_WRAP_EN
                        sel_d = SEL_LAST;
`else
                        sel_d = sel;
`endif
                    end else begin
                        sel_d = sel - SEL_W'(1);
                    end
                end
            end
            S_EDIT: begin
                if (press_c) begin
                    options_d[int'(sel) * PARAM_W +: PARAM_W] = sw_param;
                    param_wr_d = 1'b1;
                    state_d    = S_SELECT;
                end else if (blink_cnt == BLK_LAST) begin
                    blink_cnt_d = '0;
                    blink_on_d  = ~blink_on;
                end else begin
                    blink_cnt_d = blink_cnt + BLK_W'(1);
                end
            end
            default: state_d = S_SELECT;
        endcase

        if (state_d == S_EDIT && !blink_on_d) begin
            leds_d = '0;
        end else begin
            leds_d = LED_SLOT0 >> sel_d;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_SELECT;
            sel       <= '0;
            options   <= '0;
            leds      <= LED_SLOT0;
            edit_mode <= 1'b0;
            param_wr  <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            fx_en     <= '0;
        end else begin
            state_q   <= state_d;
            sel       <= sel_d;
            options   <= options_d;
            leds      <= leds_d;
            edit_mode <= (state_d == S_EDIT);
            param_wr  <= param_wr_d;
            blink_cnt <= blink_cnt_d;
            blink_on  <= blink_on_d;
            fx_en     <= sw_en;
        end
    end

endmodule

// File: tb/tb_effect_ctrl.sv
// Testbench for effect_ctrl (N_FX=4, PARAM_W=4, DEB_CYCLES=4, BLINK_CYCLES=2).
// A behavioural model tracks every cycle; directed table steps and a few
// hand-written sequences add fixed expectations.

module tb_effect_ctrl;

    localparam int N     = 4;
    localparam int PW    = 4;
    localparam int DEB   = 4;
    localparam int BLINK = 2;
`ifdef EFFECT_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [2:0] B_L = 3'b100;
    localparam logic [2:0] B_C = 3'b010;
    localparam logic [2:0] B_R = 3'b001;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     btn_in;
    logic [N-1:0]   sw_en;
    logic [PW-1:0]  sw_param;
    logic [N-1:0]   fx_en;
    logic [N*PW-1:0] options;
    logic [1:0]     sel;
    logic [N-1:0]   leds;
    logic           edit_mode;
    logic           param_wr;

    effect_ctrl #(
        .N_FX(N), .PARAM_W(PW), .DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .sw_en(sw_en),
        .sw_param(sw_param), .fx_en(fx_en), .options(options), .sel(sel),
        .leds(leds), .edit_mode(edit_mode), .param_wr(param_wr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pw_seen = 0;

    // ---------------- behavioural reference model ----------------
    logic [2:0]    drv_q[$];   // button values present at each edge since reset
    logic [2:0]    smp_q[$];   // synchronised samples seen at each edge
    logic [2:0]    m_deb, m_arm, m_pend;
    int            m_state;    // 0 = SELECT, 1 = EDIT
    int            m_sel;
    int            m_age;      // edges spent in EDIT since entry
    logic [PW-1:0] m_opt [N];
    logic          m_pw;
    logic [N-1:0]  m_fx;

    task automatic model_reset();
        drv_q.delete();
        smp_q.delete();
        m_deb = '0; m_arm = '0; m_pend = '0;
        m_state = 0; m_sel = 0; m_age = 0;
        for (int k = 0; k < N; k++) m_opt[k] = '0;
        m_pw = 1'b0; m_fx = '0;
    endtask

    function automatic logic smp_bit(int idx, int b);
        logic [2:0] v;
        if (idx < 0) return 1'b0;
        v = smp_q[idx];
        return v[b];
    endfunction

    task automatic model_edge();
        logic [2:0] s, rise;
        bit one, same;
        int n;
        // controller acts on presses detected at the previous edge
        m_pw = 1'b0;
        one = ($countones(m_pend) == 1);
        if (m_state == 1) begin
            if (one && m_pend[1]) begin
                m_opt[m_sel] = sw_param;
                m_pw = 1'b1;
                m_state = 0;
            end else begin
                m_age++;
            end
        end else if (one) begin
            if (m_pend[1]) begin
                m_state = 1;
                m_age = 0;
            end else if (m_pend[0]) begin
                m_sel = (m_sel == N - 1) ? (WRAP ? 0 : N - 1) : m_sel + 1;
            end else begin
                m_sel = (m_sel == 0) ? (WRAP ? N - 1 : 0) : m_sel - 1;
            end
        end
        m_fx = sw_en;
        // sample seen now is the button value from two edges earlier
        drv_q.push_back(btn_in);
        s = (drv_q.size() >= 3) ? drv_q[drv_q.size() - 3] : 3'b000;
        smp_q.push_back(s);
        n = smp_q.size();
        rise = '0;
        for (int b = 0; b < 3; b++) begin
            same = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (smp_bit(n - 1 - j, b) != s[b]) same = 1'b0;
            if (same && s[b] != m_deb[b]) begin
                m_deb[b] = s[b];
                rise[b] = s[b] & m_arm[b];
            end
            // first two samples after reset are synchroniser reset values
            if (!m_arm[b] && (n - DEB) >= 2 && same && !s[b]) m_arm[b] = 1'b1;
        end
        m_pend = rise;
    endtask

    task automatic check_cycle();
        logic [N*PW-1:0] eo;
        logic [N-1:0] oh, el;
        for (int k = 0; k < N; k++) eo[k*PW +: PW] = m_opt[k];
        oh = 4'b1000;
        oh = oh >> m_sel;
        el = (m_state == 1 && ((m_age / BLINK) % 2) != 0) ? 4'b0000 : oh;
        checks++;
        if (fx_en !== m_fx || options !== eo || int'(sel) != m_sel || leds !== el ||
            edit_mode !== (m_state == 1) || param_wr !== m_pw) begin
            errors++;
            $display("FAIL cycle %0d outputs: got fx=%b opt=%h sel=%0d leds=%b edit=%b wr=%b; want fx=%b opt=%h sel=%0d leds=%b edit=%b wr=%b",
                     cyc, fx_en, options, sel, leds, edit_mode, param_wr,
                     m_fx, eo, m_sel, el, (m_state == 1), m_pw);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        cyc++;
        if (param_wr) pw_seen++;
        if (!rst) check_cycle();
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_opts",  32'(options),   32'd0);
        chk("rst_fx",    32'(fx_en),     32'd0);
        chk("rst_leds",  32'(leds),      32'b1000);
        chk("rst_edit",  32'(edit_mode), 32'd0);
        chk("rst_wr",    32'(param_wr),  32'd0);
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic press(input logic [2:0] b, input int hold, input int rel);
        btn_in = b;
        repeat (hold) tick();
        btn_in = '0;
        repeat (rel) tick();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  btn;
        logic [3:0]  prm;
        logic [3:0]  en;
        int          sel_w;
        int          sel_s;
        logic        edit;
        logic [15:0] opt_w;
        logic [15:0] opt_s;
        int          wr;
    } step_t;

    step_t tbl [12];

    initial begin
        int n, kind, hold, esel;
        logic [2:0] pat;
        logic [3:0] eled;
        logic [15:0] eopt;
        bit bounce;

        tbl[0]  = '{B_R,     4'h0, 4'b1010, 1, 1, 1'b0, 16'h0000, 16'h0000, 0};
        tbl[1]  = '{B_R,     4'h0, 4'b0101, 2, 2, 1'b0, 16'h0000, 16'h0000, 0};
        tbl[2]  = '{B_C,     4'h0, 4'b1010, 2, 2, 1'b1, 16'h0000, 16'h0000, 0};
        tbl[3]  = '{B_R,     4'h0, 4'b1010, 2, 2, 1'b1, 16'h0000, 16'h0000, 0};
        tbl[4]  = '{B_L,     4'h0, 4'b0110, 2, 2, 1'b1, 16'h0000, 16'h0000, 0};
        tbl[5]  = '{B_C,     4'hA, 4'b1111, 2, 2, 1'b0, 16'h0A00, 16'h0A00, 1};
        tbl[6]  = '{B_R,     4'hA, 4'b0000, 3, 3, 1'b0, 16'h0A00, 16'h0A00, 0};
        tbl[7]  = '{B_R,     4'h0, 4'b1000, 0, 3, 1'b0, 16'h0A00, 16'h0A00, 0};
        tbl[8]  = '{B_L,     4'h0, 4'b0001, 3, 2, 1'b0, 16'h0A00, 16'h0A00, 0};
        tbl[9]  = '{B_L|B_R, 4'h0, 4'b0011, 3, 2, 1'b0, 16'h0A00, 16'h0A00, 0};
        tbl[10] = '{B_C,     4'h5, 4'b1100, 3, 2, 1'b1, 16'h0A00, 16'h0A00, 0};
        tbl[11] = '{B_C,     4'h5, 4'b1010, 3, 2, 1'b0, 16'h5A00, 16'h0500, 1};

        rst = 1'b1; btn_in = '0; sw_en = '0; sw_param = '0;
        model_reset();
        @(negedge clk);
        apply_reset(2);
        repeat (10) tick();

        // table-driven press steps
        for (int i = 0; i < 12; i++) begin
            btn_in = tbl[i].btn; sw_param = tbl[i].prm; sw_en = tbl[i].en;
            pw_seen = 0;
            repeat (10) tick();
            btn_in = '0;
            repeat (10) tick();
            esel = WRAP ? tbl[i].sel_w : tbl[i].sel_s;
            eopt = WRAP ? tbl[i].opt_w : tbl[i].opt_s;
            chk($sformatf("step%0d_sel", i),  32'(sel),       32'(esel));
            chk($sformatf("step%0d_edit", i), 32'(edit_mode), 32'(tbl[i].edit));
            chk($sformatf("step%0d_opts", i), 32'(options),   32'(eopt));
            chk($sformatf("step%0d_fx", i),   32'(fx_en),     32'(tbl[i].en));
            chk($sformatf("step%0d_wr", i),   32'(pw_seen),   32'(tbl[i].wr));
            if (!tbl[i].edit) begin
                eled = 4'b1000;
                eled = eled >> esel;
                chk($sformatf("step%0d_leds", i), 32'(leds), 32'(eled));
            end
        end

        // bouncing R, then stable: exactly one press at fixed latency
        apply_reset(2);
        repeat (10) tick();
        for (int i = 0; i < 20; i++) begin
            btn_in = (((i / 2) % 2) == 0) ? B_R : 3'b000;
            tick();
        end
        chk("bounce_no_press", 32'(sel), 32'd0);
        btn_in = B_R;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (sel == 2'd1) break;
        end
        chk("bounce_latency", 32'(n), 32'(DEB + 3));
        repeat (10) tick();
        btn_in = '0;
        repeat (10) tick();
        chk("bounce_one_press", 32'(sel), 32'd1);

        // reset during EDIT with C held through reset release
        apply_reset(2);
        repeat (10) tick();
        press(B_C, 10, 10);
        chk("enter_edit", 32'(edit_mode), 32'd1);
        sw_param = 4'hF;
        btn_in = B_C;
        repeat (3) tick();
        apply_reset(2);
        repeat (15) tick();
        chk("held_rst_edit", 32'(edit_mode), 32'd0);
        chk("held_rst_opts", 32'(options),   32'd0);
        btn_in = '0;
        repeat (10) tick();
        chk("held_rst_release", 32'(edit_mode), 32'd0);
        press(B_C, 10, 10);
        chk("rearm_edit", 32'(edit_mode), 32'd1);
        press(B_C, 10, 10);
        chk("rearm_write", 32'(options), 32'h000F);

        // randomised traffic against the model
        apply_reset(2);
        repeat (10) tick();
        for (int s = 0; s < 300; s++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 12);
            bounce = 1'b0;
            if (kind <= 5)      pat = 3'(3'b001 << $urandom_range(0, 2));
            else if (kind == 6) pat = 3'($urandom_range(1, 7));
            else if (kind == 7) pat = 3'b000;
            else begin
                pat = 3'b000;
                bounce = 1'b1;
            end
            sw_param = 4'($urandom);
            for (int h = 0; h < hold; h++) begin
                btn_in = bounce ? 3'($urandom) : pat;
                if ($urandom_range(0, 3) == 0) sw_en = 4'($urandom);
                tick();
            end
            btn_in = '0;
            repeat ($urandom_range(0, 8)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
